// File: rtl/fpga_board_rst_io_cond.sv
// Board reset/IO conditioning: lock-qualified, stretched active-low SoC reset
// sequencer plus per-channel synchronised debouncers with edge pulses.

module fpga_board_rst_io_cond_db_lane #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 20000,
    parameter logic INIT_BIT        = 1'b0
) (
    input  logic ref_clk,
    input  logic pad_reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_db;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_s;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge ref_clk or posedge pad_reset) begin
        if (pad_reset) begin
            r_sync <= {SYNC_STAGES{INIT_BIT}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Counter only runs while the synchronised level disagrees with the
    // accepted one; any return to the accepted level restarts it from zero.
    always_ff @(posedge ref_clk or posedge pad_reset) begin
        if (pad_reset) begin
            r_cnt  <= '0;
            r_db   <= INIT_BIT;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_s == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_db   <= w_s;
                r_cnt  <= '0;
                r_rise <= w_s;
                r_fall <= ~w_s;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_rise;
    assign o_fall = r_fall;
endmodule

module fpga_board_rst_io_cond #(
    parameter int                NUM_IN             = 8,
    parameter int                SYNC_STAGES        = 2,
    parameter int                DEBOUNCE_CYCLES    = 20000,
    parameter int                RST_STRETCH_CYCLES = 64,
    parameter logic [NUM_IN-1:0] INIT_VAL           = {NUM_IN{1'b0}}
) (
    input  logic              ref_clk,
    input  logic              pad_reset,
    input  logic              pll_locked_i,
    input  logic [NUM_IN-1:0] in_raw_i,
    output logic [NUM_IN-1:0] in_db_o,
    output logic [NUM_IN-1:0] in_rise_o,
    output logic [NUM_IN-1:0] in_fall_o,
    output logic              soc_rst_no,
    output logic [1:0]        rst_state_o
);
    localparam int SW = (RST_STRETCH_CYCLES > 1) ? $clog2(RST_STRETCH_CYCLES) : 1;
    localparam logic [SW-1:0] STRETCH_MAX = SW'(RST_STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RESET     = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STRETCH   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_lock_sync;
    logic                   w_lock_s;
    state_t                 r_state;
    logic [SW-1:0]          r_stretch_cnt;
    logic                   r_soc_rst_n;

    assign w_lock_s = r_lock_sync[SYNC_STAGES-1];

    always_ff @(posedge ref_clk or posedge pad_reset) begin
        if (pad_reset) begin
            r_lock_sync <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked_i};
        end
    end

    // soc_rst_no is set on the transition into S_RUN so the first S_RUN
    // cycle already shows the release; release is never asynchronous.
    always_ff @(posedge ref_clk or posedge pad_reset) begin
        if (pad_reset) begin
            r_state       <= S_RESET;
            r_stretch_cnt <= '0;
            r_soc_rst_n   <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state     <= S_WAIT_LOCK;
                    r_soc_rst_n <= 1'b0;
                end
                S_WAIT_LOCK: begin
                    r_soc_rst_n <= 1'b0;
                    if (w_lock_s) begin
                        r_stretch_cnt <= '0;
                        r_state       <= S_STRETCH;
                    end
                end
                S_STRETCH: begin
                    r_stretch_cnt <= r_stretch_cnt + SW'(1);
                    if (!w_lock_s) begin
                        r_state <= S_WAIT_LOCK;
                    end else if (r_stretch_cnt == STRETCH_MAX) begin
                        r_state     <= S_RUN;
                        r_soc_rst_n <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!w_lock_s) begin
                        r_state     <= S_WAIT_LOCK;
                        r_soc_rst_n <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign soc_rst_no  = r_soc_rst_n;
    assign rst_state_o = r_state;

    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_lane
        fpga_board_rst_io_cond_db_lane #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INIT_BIT        (INIT_VAL[gi])
        ) u_lane (
            .ref_clk   (ref_clk),
            .pad_reset (pad_reset),
            .i_raw     (in_raw_i[gi]),
            .o_db      (in_db_o[gi]),
            .o_rise    (in_rise_o[gi]),
            .o_fall    (in_fall_o[gi])
        );
    end
endmodule

// File: tb/tb_fpga_board_rst_io_cond.sv
// Bench for fpga_board_rst_io_cond: directed sequencing/debounce scenarios and
// randomized traffic against a history-window reference model.

module tb_fpga_board_rst_io_cond;
    localparam int N  = 8;
    localparam int SY = 2;
    localparam int DB = 16;
    localparam int ST = 64;
    localparam int HL = SY + DB;

    logic          ref_clk = 1'b0;
    logic          pad_reset = 1'b0;
    logic          pll_locked_i = 1'b0;
    logic [N-1:0]  in_raw_i = '0;
    logic [N-1:0]  in_db_o, in_rise_o, in_fall_o;
    logic          soc_rst_no;
    logic [1:0]    rst_state_o;

    int total = 0;
    int bad   = 0;

    fpga_board_rst_io_cond #(
        .NUM_IN(N), .SYNC_STAGES(SY), .DEBOUNCE_CYCLES(DB),
        .RST_STRETCH_CYCLES(ST), .INIT_VAL({N{1'b0}})
    ) dut (
        .ref_clk(ref_clk), .pad_reset(pad_reset), .pll_locked_i(pll_locked_i),
        .in_raw_i(in_raw_i), .in_db_o(in_db_o), .in_rise_o(in_rise_o),
        .in_fall_o(in_fall_o), .soc_rst_no(soc_rst_no), .rst_state_o(rst_state_o)
    );

    always #5 ref_clk = ~ref_clk;

    // Reference model: a level is accepted once the synchronised input has
    // disagreed with the accepted level on DB consecutive edges; the SoC is
    // released once lock_s has been high on ST+1 consecutive edges.
    logic [N-1:0] hist [0:HL-1];
    logic         lhist [0:SY];
    int           lock_run;
    logic [N-1:0] m_db, m_rise, m_fall;
    logic         m_soc;
    logic [1:0]   m_state;

    task automatic model_reset();
        for (int k = 0; k < HL; k++) hist[k] = '0;
        for (int k = 0; k <= SY; k++) lhist[k] = 1'b0;
        lock_run = 0;
        m_db = '0; m_rise = '0; m_fall = '0; m_soc = 1'b0; m_state = 2'd0;
    endtask

    task automatic model_step();
        logic ok;
        for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = in_raw_i;
        m_rise = '0;
        m_fall = '0;
        for (int ch = 0; ch < N; ch++) begin
            ok = 1'b1;
            for (int j = 0; j < DB; j++)
                if (hist[SY+j][ch] == m_db[ch]) ok = 1'b0;
            if (ok) begin
                m_db[ch] = ~m_db[ch];
                if (m_db[ch]) m_rise[ch] = 1'b1;
                else          m_fall[ch] = 1'b1;
            end
        end
        for (int k = SY; k > 0; k--) lhist[k] = lhist[k-1];
        lhist[0] = pll_locked_i;
        lock_run = lhist[SY] ? lock_run + 1 : 0;
        m_soc   = (lock_run >= ST + 1);
        m_state = m_soc ? 2'd3 : (lock_run > 0) ? 2'd2 : 2'd1;
    endtask

    task automatic tick();
        @(posedge ref_clk);
        if (pad_reset) model_reset();
        else           model_step();
        @(negedge ref_clk);
    endtask

    task automatic test_reset();
        pll_locked_i = 1'b1;
        in_raw_i = '0;
        #3 pad_reset = 1'b1;
        model_reset();
        #1;
        total++; if (soc_rst_no !== 1'b0) begin bad++; $display("FAIL reset_soc got=%b want=0", soc_rst_no); end
        total++; if (rst_state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", rst_state_o); end
        total++; if (in_db_o !== '0) begin bad++; $display("FAIL reset_db got=%h want=00", in_db_o); end
        total++; if ((in_rise_o | in_fall_o) !== '0) begin bad++; $display("FAIL reset_pulse rise=%h fall=%h want=0", in_rise_o, in_fall_o); end
        repeat (3) tick();
        total++; if ({soc_rst_no, rst_state_o} !== 3'b000) begin bad++; $display("FAIL reset_hold soc=%b state=%0d want 0/0", soc_rst_no, rst_state_o); end
    endtask

    task automatic test_sequencing();
        int cyc, seq, nseq;
        logic [1:0] last;
        pad_reset = 1'b0;
        cyc = 0; seq = 0; nseq = 1; last = rst_state_o;
        while (soc_rst_no !== 1'b1 && cyc < 200) begin
            tick(); cyc++;
            total++;
            if ({in_db_o, in_rise_o, in_fall_o, soc_rst_no, rst_state_o} !== {m_db, m_rise, m_fall, m_soc, m_state}) begin
                bad++; $display("FAIL seq_model cyc=%0d soc=%b state=%0d want soc=%b state=%0d", cyc, soc_rst_no, rst_state_o, m_soc, m_state);
            end
            if (rst_state_o !== last) begin
                seq = (seq << 4) | int'(rst_state_o); nseq++; last = rst_state_o;
            end
        end
        total++; if (cyc != 67) begin bad++; $display("FAIL seq_latency got=%0d want=67", cyc); end
        total++; if (nseq != 4 || seq != 32'h123) begin bad++; $display("FAIL seq_states got=%0h n=%0d want=0123 n=4", seq, nseq); end
    endtask

    task automatic test_lock_loss();
        int cyc;
        pll_locked_i = 1'b0;
        cyc = 0;
        while (soc_rst_no !== 1'b0 && cyc < 20) begin tick(); cyc++; end
        total++; if (cyc != 3) begin bad++; $display("FAIL loss_latency got=%0d want=3", cyc); end
        total++; if (rst_state_o !== 2'd1) begin bad++; $display("FAIL loss_state got=%0d want=1", rst_state_o); end
        repeat (4) tick();
        pll_locked_i = 1'b1;
        cyc = 0;
        while (soc_rst_no !== 1'b1 && cyc < 200) begin
            tick(); cyc++;
            total++;
            if ({soc_rst_no, rst_state_o} !== {m_soc, m_state}) begin
                bad++; $display("FAIL relock_model cyc=%0d soc=%b state=%0d want soc=%b state=%0d", cyc, soc_rst_no, rst_state_o, m_soc, m_state);
            end
        end
        total++; if (cyc != 67) begin bad++; $display("FAIL relock_latency got=%0d want=67", cyc); end
    endtask

    task automatic test_lock_glitch();
        int cyc;
        logic saw_wait, saw_soc;
        pll_locked_i = 1'b0;
        repeat (6) tick();
        pll_locked_i = 1'b1;
        repeat (33) tick();
        total++; if (rst_state_o !== 2'd2) begin bad++; $display("FAIL glitch_pre_state got=%0d want=2", rst_state_o); end
        pll_locked_i = 1'b0;
        saw_wait = 1'b0; saw_soc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (rst_state_o === 2'd1) saw_wait = 1'b1;
            if (soc_rst_no !== 1'b0) saw_soc = 1'b1;
        end
        total++; if (!saw_wait) begin bad++; $display("FAIL glitch_wait state=%0d want return to 1", rst_state_o); end
        pll_locked_i = 1'b1;
        cyc = 0;
        while (soc_rst_no !== 1'b1 && cyc < 200) begin tick(); cyc++; end
        total++; if (cyc != 67) begin bad++; $display("FAIL glitch_restretch got=%0d want=67", cyc); end
        total++; if (saw_soc) begin bad++; $display("FAIL glitch_soc got=1 want=0 during glitch"); end
    endtask

    task automatic test_debounce_accept();
        int cyc, nrise, nfall;
        in_raw_i[0] = 1'b1;
        cyc = 0; nrise = 0; nfall = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (in_db_o[0] === 1'b1 && cyc == 0) cyc = k;
            if (in_rise_o[0] === 1'b1) nrise++;
            if (in_fall_o !== '0) nfall++;
            total++;
            if ({in_db_o, in_rise_o, in_fall_o} !== {m_db, m_rise, m_fall}) begin
                bad++; $display("FAIL accept_model k=%0d db=%h rise=%h fall=%h want %h/%h/%h", k, in_db_o, in_rise_o, in_fall_o, m_db, m_rise, m_fall);
            end
        end
        total++; if (cyc != SY + DB) begin bad++; $display("FAIL accept_latency got=%0d want=%0d", cyc, SY + DB); end
        total++; if (nrise != 1) begin bad++; $display("FAIL accept_rise_cnt got=%0d want=1", nrise); end
        total++; if (nfall != 0) begin bad++; $display("FAIL accept_fall_cnt got=%0d want=0", nfall); end
        in_raw_i[0] = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_bounce_reject();
        int cyc, nevt;
        nevt = 0;
        for (int r = 0; r < 4; r++) begin
            in_raw_i[3] = 1'b1;
            repeat (10) begin tick(); if ((in_db_o[3] | in_rise_o[3] | in_fall_o[3]) !== 1'b0) nevt++; end
            in_raw_i[3] = 1'b0;
            repeat (2) begin tick(); if ((in_db_o[3] | in_rise_o[3] | in_fall_o[3]) !== 1'b0) nevt++; end
        end
        total++; if (nevt != 0) begin bad++; $display("FAIL bounce_reject events=%0d want=0", nevt); end
        in_raw_i[3] = 1'b1;
        cyc = 0;
        while (in_db_o[3] !== 1'b1 && cyc < 60) begin tick(); cyc++; end
        total++; if (cyc != SY + DB) begin bad++; $display("FAIL bounce_accept got=%0d want=%0d", cyc, SY + DB); end
        in_raw_i[3] = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_random();
        int nacc;
        nacc = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 19) == 0) in_raw_i[b] = ~in_raw_i[b];
            if (pll_locked_i && $urandom_range(0, 399) == 0) pll_locked_i = 1'b0;
            else if (!pll_locked_i && $urandom_range(0, 9) == 0) pll_locked_i = 1'b1;
            tick();
            if ((m_rise | m_fall) != '0) nacc++;
            total++;
            if ({in_db_o, in_rise_o, in_fall_o, soc_rst_no, rst_state_o} !== {m_db, m_rise, m_fall, m_soc, m_state}) begin
                bad++; $display("FAIL rand_model c=%0d db=%h r=%h f=%h soc=%b st=%0d want %h/%h/%h/%b/%0d", c, in_db_o, in_rise_o, in_fall_o, soc_rst_no, rst_state_o, m_db, m_rise, m_fall, m_soc, m_state);
            end
        end
        total++; if (nacc == 0) begin bad++; $display("FAIL rand_activity accepts=0 want>0"); end
    endtask

    task automatic test_async_reset();
        in_raw_i = '0;
        pll_locked_i = 1'b1;
        repeat (150) tick();
        in_raw_i = 8'hA5;
        repeat (SY + DB) tick();
        total++; if ({soc_rst_no, in_db_o, in_rise_o} !== {1'b1, 8'hA5, 8'hA5}) begin
            bad++; $display("FAIL ar_pre soc=%b db=%h rise=%h want 1/a5/a5", soc_rst_no, in_db_o, in_rise_o);
        end
        #2 pad_reset = 1'b1;
        model_reset();
        #1;
        total++; if ({soc_rst_no, rst_state_o} !== 3'b000) begin bad++; $display("FAIL ar_soc soc=%b state=%0d want 0/0", soc_rst_no, rst_state_o); end
        total++; if (in_db_o !== 8'h00) begin bad++; $display("FAIL ar_db got=%h want=00", in_db_o); end
        total++; if ((in_rise_o | in_fall_o) !== 8'h00) begin bad++; $display("FAIL ar_pulse rise=%h fall=%h want=0", in_rise_o, in_fall_o); end
        @(negedge ref_clk);
        repeat (2) tick();
        pad_reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if ({in_db_o, in_rise_o, in_fall_o, soc_rst_no, rst_state_o} !== {m_db, m_rise, m_fall, m_soc, m_state}) begin
                bad++; $display("FAIL ar_exit k=%0d db=%h r=%h f=%h soc=%b st=%0d want %h/%h/%h/%b/%0d", k, in_db_o, in_rise_o, in_fall_o, soc_rst_no, rst_state_o, m_db, m_rise, m_fall, m_soc, m_state);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequencing();
        test_lock_loss();
        test_lock_glitch();
        test_debounce_accept();
        test_bounce_reject();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fpga_board_rst_io_cond.md
Name: fpga_board_rst_io_cond

Overview:
Board-level reset and I/O conditioning block for the FPGA target top levels. It sits between raw board pins (buttons, switches, PLL lock) and the SoC instance. It produces a clean, stretched, lock-qualified active-low SoC reset, plus debounced, synchronised copies of NUM_IN asynchronous board inputs with edge pulses. It replaces ad-hoc reset inversion with a parametrised, sequential reset sequencer.

Parameters:
NUM_IN, 8, number of debounced board input channels (1..32)
SYNC_STAGES, 2, synchroniser flops per async input (>=2)
DEBOUNCE_CYCLES, 20000, consecutive stable ref_clk cycles required to accept a new input level (>=2)
RST_STRETCH_CYCLES, 64, ref_clk cycles the SoC reset is held after lock before release (>=1)
INIT_VAL, {NUM_IN{1'b0}}, debounced output value while in reset

Ports:
ref_clk  input  1  single system clock, already single-ended
pad_reset  input  1  asynchronous, active-high reset
pll_locked_i  input  1  asynchronous PLL/MMCM lock indication
in_raw_i  input  NUM_IN  raw asynchronous board inputs (buttons/switches)
in_db_o  output  NUM_IN  debounced input levels
in_rise_o  output  NUM_IN  one-cycle pulse on accepted 0->1 transition
in_fall_o  output  NUM_IN  one-cycle pulse on accepted 1->0 transition
soc_rst_no  output  1  active-low reset to SoC
rst_state_o  output  2  current sequencer state (debug)

Behaviour:
- One clock (ref_clk); reset is asynchronous and active-high (pad_reset).
- Reset values: soc_rst_no=0, rst_state_o=0 (S_RESET), in_db_o=INIT_VAL, in_rise_o=0, in_fall_o=0; all sync flops loaded with INIT_VAL (inputs) / 0 (lock); all counters 0.
- pad_reset assertion drives soc_rst_no low asynchronously, same as all other outputs. Deassertion is synchronous via the sequencer only.
- pll_locked_i passes through a SYNC_STAGES synchroniser giving lock_s.
- Sequencer states: S_RESET=0, S_WAIT_LOCK=1, S_STRETCH=2, S_RUN=3.
  - S_RESET: next cycle goes to S_WAIT_LOCK.
  - S_WAIT_LOCK: stays while lock_s=0. When lock_s=1, clears the stretch counter and goes to S_STRETCH.
  - S_STRETCH: counter increments each cycle. When lock_s=0, goes to S_WAIT_LOCK. When counter==RST_STRETCH_CYCLES-1 and lock_s=1, goes to S_RUN.
  - S_RUN: soc_rst_no=1. When lock_s=0, goes to S_WAIT_LOCK.
- soc_rst_no is a registered output, 1 only in S_RUN. First cycle of S_RUN shows soc_rst_no=1.
- Latency, lock edge to soc_rst_no rise: SYNC_STAGES + 1 + RST_STRETCH_CYCLES cycles.
- Lock loss in S_RUN: soc_rst_no falls SYNC_STAGES+1 cycles after the pll_locked_i fall.
- Debounce, per channel i, independent:
  - in_raw_i[i] passes through a SYNC_STAGES synchroniser giving s[i].
  - When s[i]==in_db_o[i], cnt[i] is cleared.
  - Otherwise cnt[i] increments. When cnt[i]==DEBOUNCE_CYCLES-1, in_db_o[i] takes s[i], cnt[i] clears, and the matching rise/fall pulse fires in that same cycle for exactly one cycle.
  - Any glitch returning to the stable level before acceptance restarts counting from 0.
  - Counter width is $clog2(DEBOUNCE_CYCLES). The counter never wraps, because it clears on acceptance.
- Debouncers run in all sequencer states; they are reset only by pad_reset.
- Simultaneous transitions on several channels are accepted independently in the same cycle.
- pad_reset mid-sequence or mid-debounce restores all reset values immediately. No pulse is generated on reset entry or exit.

Test Plan:
- Sequencing: assert pad_reset, release with pll_locked_i=1, RST_STRETCH_CYCLES=64, SYNC_STAGES=2 -> soc_rst_no rises exactly 67 cycles after release; rst_state_o goes 0,1,2,3.
- Lock loss: in S_RUN drop pll_locked_i -> soc_rst_no=0 after 3 cycles, rst_state_o=1. Re-lock -> release after 67 cycles.
- Lock glitch during stretch: drop lock at stretch count 30 for 5 cycles -> sequencer returns to S_WAIT_LOCK and restarts the full 64-cycle stretch after re-lock.
- Debounce accept: DEBOUNCE_CYCLES=16, hold in_raw_i[0]=1 -> in_db_o[0] rises SYNC_STAGES+16 cycles after the input edge; in_rise_o[0] is one cycle high; in_fall_o stays 0.
- Bounce reject: toggle in_raw_i[3] with 10-cycle high pulses separated by 2-cycle lows (DEBOUNCE_CYCLES=16) -> in_db_o[3] stays 0, no pulses. Then hold high -> accepted 18 cycles after the last edge.
- Async reset mid-operation: assert pad_reset in S_RUN with in_db_o=8'hA5 -> soc_rst_no=0, in_db_o=INIT_VAL, no rise/fall pulses, all within the same cycle without any clock edge.
